// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receive port.
// Holds the receiver state encoding, the default register addresses
// and the bit positions inside the status register.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] DEFAULT_DATA_ADDR   = 8'hFE;
  localparam logic [7:0] DEFAULT_STATUS_ADDR = 8'hFD;

  localparam int VALID_B = 0;
  localparam int OVR_B   = 1;
  localparam int FERR_B  = 2;
  localparam int FULL_B  = 3;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial deserializer: synchronizes the asynchronous rx line, finds
// the start bit, samples each bit near its centre and reports either a
// received byte (byte_stb) or a framing error (ferr_stb) for one cycle.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_stb,
  output logic       ferr_stb
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_t       state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            wait_high;

  // Two-flop synchronizer; resets to the idle-high line level so no false start is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame FSM: baud counter reloads on each state entry and a sample is taken when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= FULL_RELOAD;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      wait_high <= 1'b0;
      byte_o    <= 8'h00;
      byte_stb  <= 1'b0;
      ferr_stb  <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      ferr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (wait_high) begin
            if (rx_sync) begin
              wait_high <= 1'b0;
            end
          end else if (!rx_sync) begin
            state    <= START;
            baud_cnt <= HALF_RELOAD;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            if (!rx_sync) begin
              state    <= DATA;
              baud_cnt <= FULL_RELOAD;
              bit_cnt  <= 3'd0;
            end else begin
              state    <= IDLE;
              baud_cnt <= FULL_RELOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            shreg    <= {rx_sync, shreg[7:1]};
            baud_cnt <= FULL_RELOAD;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == '0) begin
            if (rx_sync) begin
              byte_o   <= shreg;
              byte_stb <= 1'b1;
            end else begin
              ferr_stb  <= 1'b1;
              wait_high <= 1'b1;
            end
            state    <= IDLE;
            baud_cnt <= FULL_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= FULL_RELOAD;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receive port: buffers bytes from uart_rx_core and
// exposes a data register and a status register {5'b0/full, ferr, ovr, valid}
// on the CPU data address bus. Define UART_RX_FIFO_EN to replace the
// single-byte buffer with a FIFO_DEPTH-entry circular FIFO.
module uart_rx_port
  import uart_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] DATA_ADDR    = DEFAULT_DATA_ADDR,
  parameter logic [7:0] STATUS_ADDR  = DEFAULT_STATUS_ADDR,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] Address,
  input  logic       rd_en,
  output logic [7:0] RxData,
  output logic       sel,
  output logic       irq
);

  logic [7:0] byte_o;
  logic       byte_stb;
  logic       ferr_stb;
  logic       consume;
  logic       status_clr;
  logic       valid;
  logic       full;
  logic       ovr;
  logic       ferr;
  logic       ovr_set;
  logic [7:0] head;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .byte_o  (byte_o),
    .byte_stb(byte_stb),
    .ferr_stb(ferr_stb)
  );

  assign consume    = rd_en && (Address == DATA_ADDR);
  assign status_clr = rd_en && (Address == STATUS_ADDR);

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign pop     = consume && !empty;
  assign push    = byte_stb && (!full || pop);
  assign ovr_set = byte_stb && full && !pop;
  assign valid   = !empty;
  assign head    = mem[rd_ptr[PW-2:0]];

  // Circular FIFO; a pop frees the head slot in the same cycle so a push while full still fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[PW-2:0]] <= byte_o;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
`else
  logic [7:0] rx_buf;

  assign full    = 1'b0;
  assign ovr_set = byte_stb && valid && !consume;
  assign head    = rx_buf;

  // Single-byte buffer; a commit is only accepted when empty or being read in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf <= 8'h00;
      valid  <= 1'b0;
    end else begin
      if (byte_stb && (!valid || consume)) begin
        rx_buf <= byte_o;
        valid  <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
      end
    end
  end
`endif

  // Sticky error flags cleared by a status read; a same-cycle set takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  || (ovr  && !status_clr);
      ferr <= ferr_stb || (ferr && !status_clr);
    end
  end

  // Read mux and select decode for the CPU data path.
  always_comb begin
    RxData = 8'h00;
    sel    = 1'b0;
    if (Address == DATA_ADDR) begin
      RxData = head;
      sel    = 1'b1;
    end else if (Address == STATUS_ADDR) begin
      RxData         = 8'h00;
      RxData[VALID_B] = valid;
      RxData[OVR_B]   = ovr;
      RxData[FERR_B]  = ferr;
      RxData[FULL_B]  = full;
      sel            = 1'b1;
    end
  end

  assign irq = valid;

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port with CLKS_PER_BIT = 16.
// Expected values come from a queue-based model of received bytes plus
// two sticky error flags. Build with UART_RX_FIFO_EN to exercise the FIFO.
module tb_uart_rx_port;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP     = DEPTH;
  localparam bit FIFO_ON = 1'b1;
`else
  localparam int CAP     = 1;
  localparam bit FIFO_ON = 1'b0;
`endif
  localparam logic [7:0] DADDR = 8'hFE;
  localparam logic [7:0] SADDR = 8'hFD;

  typedef struct {
    logic [7:0] addr;
    logic       exp_sel;
    logic [7:0] exp_data;
  } dec_vec_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] Address;
  logic       rd_en;
  logic [7:0] RxData;
  logic       sel;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_ferr;

  uart_rx_port #(
    .CLKS_PER_BIT(CPB),
    .DATA_ADDR   (DADDR),
    .STATUS_ADDR (SADDR),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .Address(Address),
    .rd_en  (rd_en),
    .RxData (RxData),
    .sel    (sel),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] expStatus();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (q.size() != 0);
    s[1] = m_ovr;
    s[2] = m_ferr;
    s[3] = FIFO_ON && (q.size() == CAP);
    return s;
  endfunction

  task automatic modelReset();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Reads a register; with consume set, also pulses rd_en and updates the model.
  task automatic readReg(input logic [7:0] a, input bit consume, output logic [7:0] d);
    Address = a;
    #2;
    d = RxData;
    if (consume) begin
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      if (a == DADDR && q.size() > 0) void'(q.pop_front());
      if (a == SADDR) begin
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
    end
    Address = 8'h00;
  endtask

  task automatic checkStatus(input string name);
    logic [7:0] d;
    readReg(SADDR, 1'b0, d);
    checkOutput(name, d, expStatus());
    checkOutput({name, "_irq"}, {7'b0, irq}, {7'b0, q.size() != 0});
  endtask

  // Sends one 8N1 frame; stop_ok = 0 drives a low stop bit.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    checkOutput("irq_before_stop", {7'b0, irq}, {7'b0, q.size() != 0});
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(4);
    if (!stop_ok) m_ferr = 1'b1;
    else if (q.size() < CAP) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  initial begin
    dec_vec_t   vecs[8];
    logic [7:0] d;
    logic [7:0] exp;
    logic [7:0] ra;

    rst     = 1'b1;
    rx      = 1'b1;
    Address = 8'h00;
    rd_en   = 1'b0;
    modelReset();
    tick(3);
    rst = 1'b0;
    tick(2);

    vecs[0] = '{8'hFE, 1'b1, 8'h00};
    vecs[1] = '{8'hFD, 1'b1, 8'h00};
    vecs[2] = '{8'h00, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 1'b0, 8'h00};
    vecs[4] = '{8'hFC, 1'b0, 8'h00};
    vecs[5] = '{8'h7E, 1'b0, 8'h00};
    vecs[6] = '{8'h7D, 1'b0, 8'h00};
    vecs[7] = '{8'h01, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      Address = vecs[i].addr;
      #2;
      checkOutput($sformatf("reset_sel_%h", vecs[i].addr), {7'b0, sel}, {7'b0, vecs[i].exp_sel});
      checkOutput($sformatf("reset_data_%h", vecs[i].addr), RxData, vecs[i].exp_data);
      tick(1);
    end
    Address = 8'h00;
    checkOutput("reset_irq", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      ra      = 8'($urandom);
      Address = ra;
      #2;
      checkOutput("rand_addr_sel", {7'b0, sel}, {7'b0, (ra == DADDR) || (ra == SADDR)});
      tick(1);
    end

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1);
    readReg(SADDR, 1'b0, d);
    checkOutput("a5_status", d, 8'h01);
    checkOutput("a5_irq", {7'b0, irq}, 8'h01);
    readReg(DADDR, 1'b1, d);
    checkOutput("a5_data", d, 8'hA5);
    readReg(SADDR, 1'b0, d);
    checkOutput("a5_status_after_read", d, 8'h00);

`ifndef UART_RX_FIFO_EN
    $display("[TB] overrun with two unread frames");
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    readReg(DADDR, 1'b0, d);
    checkOutput("ovr_data", d, 8'h3C);
    readReg(SADDR, 1'b1, d);
    checkOutput("ovr_status", d, 8'h03);
    readReg(SADDR, 1'b0, d);
    checkOutput("ovr_status_cleared", d, 8'h01);
    readReg(DADDR, 1'b1, d);
`else
    $display("[TB] FIFO fill past depth");
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
    readReg(SADDR, 1'b0, d);
    checkOutput("fifo_status_full", d, 8'h0B);
    for (int i = 1; i <= 4; i++) begin
      readReg(DADDR, 1'b1, d);
      checkOutput($sformatf("fifo_data_%0d", i), d, 8'(i));
    end
    readReg(SADDR, 1'b1, d);
    checkOutput("fifo_status_drained", d, 8'h02);
`endif
    checkStatus("after_ovr_seq");

    $display("[TB] framing error then recovery");
    applyStimulus(8'h55, 1'b0);
    readReg(SADDR, 1'b0, d);
    checkOutput("ferr_status", d, 8'h04);
    checkOutput("ferr_irq", {7'b0, irq}, 8'h00);
    tick(20);
    applyStimulus(8'h12, 1'b1);
    readReg(DADDR, 1'b0, d);
    checkOutput("recover_data", d, 8'h12);
    readReg(SADDR, 1'b1, d);
    checkOutput("recover_status", d, 8'h05);
    readReg(DADDR, 1'b1, d);
    checkStatus("recover_cleared");

    $display("[TB] short glitch on rx");
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    readReg(SADDR, 1'b0, d);
    checkOutput("glitch_status", d, 8'h00);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h77, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 8'h0F >> i;
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    modelReset();
    tick(30);
    readReg(SADDR, 1'b0, d);
    checkOutput("midreset_status", d, 8'h00);
    readReg(DADDR, 1'b0, d);
    checkOutput("midreset_data", d, 8'h00);
    checkOutput("midreset_irq", {7'b0, irq}, 8'h00);
    applyStimulus(8'h81, 1'b1);
    readReg(DADDR, 1'b1, d);
    checkOutput("post_reset_data", d, 8'h81);
    checkStatus("post_reset_status");

    $display("[TB] randomized frames");
    for (int n = 0; n < 14; n++) begin
      int act;
      applyStimulus(8'($urandom), ($urandom_range(0, 5) != 0));
      act = $urandom_range(0, 3);
      if ((act == 1 || act == 3) && q.size() > 0) begin
        exp = q[0];
        readReg(DADDR, 1'b1, d);
        checkOutput("rand_data", d, exp);
      end
      if (act == 2 || act == 3) begin
        exp = expStatus();
        readReg(SADDR, 1'b1, d);
        checkOutput("rand_status", d, exp);
      end
      tick($urandom_range(1, 20));
    end
    while (q.size() > 0) begin
      exp = q[0];
      readReg(DADDR, 1'b1, d);
      checkOutput("drain_data", d, exp);
    end
    checkStatus("final_status");

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
